// File: rtl/sort_memory.sv
// Word-addressed data memory for the selection sorter: request/ready handshake with
// LATENCY wait states plus a preload port. Define MEM_STAT_EN to add read/write counters.
module sort_memory #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              readMem,
    input  logic              writeMem,
    input  logic [ADDR_W-1:0] addrBus,
    input  logic [DATA_W-1:0] outBus,
    input  logic              ldEn,
    input  logic [ADDR_W-1:0] ldAddr,
    input  logic [DATA_W-1:0] ldData,
    output logic [DATA_W-1:0] inBus,
    output logic              rdyMem,
    output logic              busy,
    output logic              collision
`ifdef MEM_STAT_EN
    ,
    output logic [15:0]       rdCnt,
    output logic [15:0]       wrCnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              coll_q, coll_d;
    logic [DATA_W-1:0] in_bus_q;
    logic              commit;
    logic              ld_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_we_d = op_we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        coll_d  = coll_q;
        commit  = 1'b0;
        ld_we   = 1'b0;
        case (state_q)
            IDLE: begin
                // A preload takes priority; a concurrent request waits for the next IDLE edge.
                if (ldEn) begin
                    ld_we = 1'b1;
                end else if (readMem || writeMem) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY);
                    op_we_d = writeMem && !readMem;
                    addr_d  = addrBus;
                    data_d  = outBus;
                    if (readMem && writeMem) begin
                        coll_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_we_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            coll_q   <= 1'b0;
            in_bus_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_we_q <= op_we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            coll_q  <= coll_d;
            if (commit && !op_we_q) begin
                in_bus_q <= mem[addr_q];
            end
        end
    end

    // Contents are deliberately not reset; an async reset forces IDLE so no commit can follow.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ldAddr] <= ldData;
        end else if (commit && op_we_q) begin
            mem[addr_q] <= data_q;
        end
    end

`ifdef MEM_STAT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (commit) begin
            if (op_we_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rdCnt = rd_cnt_q;
    assign wrCnt = wr_cnt_q;
`endif

    assign inBus     = in_bus_q;
    assign rdyMem    = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign collision = coll_q;

endmodule

// File: tb/tb_sort_memory.sv
// Directed bench for sort_memory: three instances at LATENCY 2, 0 and 4 driven by shared tasks.
module tb_sort_memory;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 4;
    endfunction

    logic        clk;
    logic        rst_n     [3];
    logic        read_mem  [3];
    logic        write_mem [3];
    logic [7:0]  addr_bus  [3];
    logic [15:0] out_bus   [3];
    logic        ld_en     [3];
    logic [7:0]  ld_addr   [3];
    logic [15:0] ld_data   [3];
    logic [15:0] in_bus    [3];
    logic        rdy       [3];
    logic        busy      [3];
    logic        coll      [3];
`ifdef MEM_STAT_EN
    logic [15:0] rd_cnt    [3];
    logic [15:0] wr_cnt    [3];
`endif

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        sort_memory #(.ADDR_W(8), .DATA_W(16), .LATENCY(lat_of(gi))) u_dut (
            .clk       (clk),
            .rst       (rst_n[gi]),
            .readMem   (read_mem[gi]),
            .writeMem  (write_mem[gi]),
            .addrBus   (addr_bus[gi]),
            .outBus    (out_bus[gi]),
            .ldEn      (ld_en[gi]),
            .ldAddr    (ld_addr[gi]),
            .ldData    (ld_data[gi]),
            .inBus     (in_bus[gi]),
            .rdyMem    (rdy[gi]),
            .busy      (busy[gi]),
            .collision (coll[gi])
`ifdef MEM_STAT_EN
            ,
            .rdCnt     (rd_cnt[gi]),
            .wrCnt     (wr_cnt[gi])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic load(input int k, input logic [7:0] a, input logic [15:0] d);
        ld_en[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
        @(negedge clk);
        ld_en[k] = 1'b0;
    endtask

    task automatic access(input int k, input bit rd, input bit wr, input logic [7:0] a,
                          input logic [15:0] d, output int lat, output logic [15:0] rdata,
                          output time e0);
        read_mem[k] = rd; write_mem[k] = wr; addr_bus[k] = a; out_bus[k] = d;
        @(posedge clk);
        e0 = $time;
        @(negedge clk);
        // Scramble the bus to prove address/data were latched at E0.
        read_mem[k] = 1'b0; write_mem[k] = 1'b0; addr_bus[k] = ~a; out_bus[k] = ~d;
        check($sformatf("busy_after_E0[%0d]", k), 32'(busy[k]), 32'd1);
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (rdy[k]) lat = c - 1;
            else @(negedge clk);
        end
        rdata = in_bus[k];
        @(negedge clk);
        check($sformatf("rdy_one_cycle[%0d]", k), 32'(rdy[k]), 32'd0);
        check($sformatf("busy_low_after[%0d]", k), 32'(busy[k]), 32'd0);
    endtask

    int          lat;
    logic [15:0] rdata;
    time         t_a, t_b;
    int          pulses;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; read_mem[i] = 1'b0; write_mem[i] = 1'b0;
            addr_bus[i] = '0; out_bus[i] = '0; ld_en[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_inBus", 32'(in_bus[0]), 32'h0);
        check("rst_rdy", 32'(rdy[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_collision", 32'(coll[0]), 32'd0);

        // Preload then read, LATENCY=2
        load(0, 8'h05, 16'hBEEF);
        access(0, 1'b1, 1'b0, 8'h05, 16'h0000, lat, rdata, t_a);
        check("l2_latency", 32'(lat), 32'd3);
        check("l2_read_05", 32'(rdata), 32'hBEEF);

        // Write then read, LATENCY=0, back-to-back with 3-cycle period
        access(1, 1'b0, 1'b1, 8'hFF, 16'h1234, lat, rdata, t_a);
        check("l0_wr_latency", 32'(lat), 32'd1);
        check("l0_inBus_kept_on_write", 32'(in_bus[1]), 32'h0);
        access(1, 1'b1, 1'b0, 8'hFF, 16'h0000, lat, rdata, t_b);
        check("l0_rd_latency", 32'(lat), 32'd1);
        check("l0_read_FF", 32'(rdata), 32'h1234);
        check("l0_period", 32'((t_b - t_a) / 10), 32'd3);

        // Collision, LATENCY=2
        load(0, 8'h10, 16'h00AA);
        access(0, 1'b1, 1'b1, 8'h10, 16'h5555, lat, rdata, t_a);
        check("coll_read_data", 32'(rdata), 32'h00AA);
        check("coll_flag", 32'(coll[0]), 32'd1);
        access(0, 1'b1, 1'b0, 8'h10, 16'h0000, lat, rdata, t_a);
        check("coll_mem_unchanged", 32'(rdata), 32'h00AA);
        check("coll_sticky", 32'(coll[0]), 32'd1);

        // Requests and preloads during WAIT are ignored
        load(0, 8'h20, 16'h1111);
        load(0, 8'h21, 16'h2222);
        read_mem[0] = 1'b1; addr_bus[0] = 8'h05;
        @(posedge clk);
        @(negedge clk);
        read_mem[0] = 1'b0; write_mem[0] = 1'b1; addr_bus[0] = 8'h20; out_bus[0] = 16'h9999;
        ld_en[0] = 1'b1; ld_addr[0] = 8'h21; ld_data[0] = 16'h7777;
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            if (rdy[0]) pulses++;
            if (c == 1) begin
                write_mem[0] = 1'b0; ld_en[0] = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_ignore_pulses", 32'(pulses), 32'd1);
        check("busy_ignore_read", 32'(in_bus[0]), 32'hBEEF);
        access(0, 1'b1, 1'b0, 8'h20, 16'h0000, lat, rdata, t_a);
        check("busy_ignore_mem20", 32'(rdata), 32'h1111);
        access(0, 1'b1, 1'b0, 8'h21, 16'h0000, lat, rdata, t_a);
        check("busy_ignore_mem21", 32'(rdata), 32'h2222);

        // Collision clears only on reset
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        check("coll_cleared_by_reset", 32'(coll[0]), 32'd0);
        check("inBus_cleared_by_reset", 32'(in_bus[0]), 32'h0);

        // Reset mid-write, LATENCY=4
        load(2, 8'h30, 16'hCAFE);
        write_mem[2] = 1'b1; addr_bus[2] = 8'h30; out_bus[2] = 16'h0BAD;
        @(posedge clk);
        @(negedge clk);
        write_mem[2] = 1'b0;
        @(negedge clk);
        check("midrst_busy_before", 32'(busy[2]), 32'd1);
        rst_n[2] = 1'b0;
        @(negedge clk);
        check("midrst_busy_in_reset", 32'(busy[2]), 32'd0);
        rst_n[2] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rdy[2]) pulses++;
        end
        check("midrst_no_rdy", 32'(pulses), 32'd0);
`ifdef MEM_STAT_EN
        check("midrst_wrCnt", 32'(wr_cnt[2]), 32'd0);
`endif
        access(2, 1'b1, 1'b0, 8'h30, 16'h0000, lat, rdata, t_a);
        check("l4_latency", 32'(lat), 32'd5);
        check("midrst_mem_kept", 32'(rdata), 32'hCAFE);
`ifdef MEM_STAT_EN
        check("stat_rdCnt", 32'(rd_cnt[2]), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_memory.md
# sort_memory

Word-addressed data memory with a wait-state request/ready handshake that serves the selection-sort controller. It sits directly downstream of the sorter: it decodes `readMem`/`writeMem` with `addrBus`, writes the sorter's `outBus`, returns read data on `inBus`, and pulses `rdyMem` when each access completes. A separate load port lets the bench preload the array before `start`.

## Interface
Parameters:
- `ADDR_W`, 8: address width; depth is 2**ADDR_W words.
- `DATA_W`, 16: word width.
- `LATENCY`, 2: wait-state cycles per access; legal range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `readMem`  in  1  read request from sorter (level).
- `writeMem`  in  1  write request from sorter (level).
- `addrBus`  in  ADDR_W  access address.
- `outBus`  in  DATA_W  write data (sorter output).
- `inBus`  out  DATA_W  read data (sorter input); registered.
- `rdyMem`  out  1  access complete; high for exactly one cycle.
- `busy`  out  1  high whenever state is not IDLE.
- `collision`  out  1  sticky; set when `readMem` and `writeMem` are both sampled high.
- `ldEn`  in  1  preload write strobe.
- `ldAddr`  in  ADDR_W  preload address.
- `ldData`  in  DATA_W  preload data.

## Operation
- States: IDLE, WAIT, DONE. A 4-bit wait counter tracks wait states.
- IDLE:
  - If `ldEn`=1, write `ldData` to `mem[ldAddr]` at the edge and stay in IDLE. A sorter request in the same cycle is not sampled; it is sampled on the next IDLE edge.
  - Else if `readMem` or `writeMem`=1, latch op, `addrBus` and `outBus`, load the counter with LATENCY, and go to WAIT.
  - If both requests are high, the access is a read, the write is dropped, and `collision` is set.
- WAIT:
  - If counter≠0, decrement and stay in WAIT.
  - If counter=0, commit the access and go to DONE.
  - A read loads `inBus` with `mem[addr]`. A write stores the latched data.
- DONE: `rdyMem`=1. Go to IDLE unconditionally on the next edge.
- Requests and `ldEn` outside IDLE are ignored. Latched address and data are unaffected by bus changes after sampling.
- Requester rule: deassert `readMem`/`writeMem` no later than the `rdyMem` cycle. A request still high in the following IDLE cycle starts a new access.
- `inBus` holds the last read value until the next read completes. Writes and loads do not change it.
- Address wraps naturally modulo 2**ADDR_W; there is no out-of-range case.
- Memory contents are not reset. They are undefined until written or loaded.
- Reset values: state IDLE, counter 0, `inBus`=0, `rdyMem`=0, `busy`=0, `collision`=0.
- Reset asserted mid-access aborts the access. A pending write is not committed, and no `rdyMem` is issued.

## Timing
- Request is sampled at edge E0, which moves IDLE→WAIT. `busy` is high from E0.
- Commit happens at edge E0+LATENCY+1 (WAIT→DONE). `rdyMem` and a valid `inBus` are high for the cycle after that edge.
- DONE→IDLE happens at edge E0+LATENCY+2. The earliest next request is sampled at E0+LATENCY+3.
- Access period is LATENCY+3 cycles; with LATENCY=0 it is 3 cycles.
- Preload takes 1 cycle per word and can be back-to-back while IDLE.
- All outputs are registered or decoded from the state register, so they are glitch-free.

## Configuration
- `MEM_STAT_EN` defined:
  - Adds outputs `rdCnt[15:0]` and `wrCnt[15:0]`.
  - Each increments by one at the commit edge of a sorter read or write, and saturates at 0xFFFF.
  - Both reset to 0.
  - Preloads, dropped collision writes and aborted accesses are not counted.
- `MEM_STAT_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset then idle: drive `rst`=0 then 1 → `inBus`=0x0000, `rdyMem`=0, `busy`=0, `collision`=0.
- Preload then read, LATENCY=2: load `mem[0x05]`=0xBEEF, then assert `readMem` at address 0x05 sampled at E0 → `rdyMem` high exactly one cycle after E0+3, `inBus`=0xBEEF, `busy` low after E0+4.
- Write then read, LATENCY=0: write 0x1234 to 0xFF, then read 0xFF → `rdyMem` in the cycle after E0+1, read returns 0x1234, each access period 3 cycles.
- Collision: `readMem`=`writeMem`=1 at address 0x10 (preloaded 0x00AA) with `outBus`=0x5555 → `inBus`=0x00AA, `mem[0x10]` unchanged, `collision` stays 1 until reset.
- Ignore while busy: a second `writeMem` to 0x20 and `ldEn` to 0x21 during WAIT → neither word changes, only one `rdyMem` pulse.
- Reset mid-write, LATENCY=4: assert `rst` during WAIT → no `rdyMem`, `mem[addr]` keeps its old value. With `MEM_STAT_EN`, `wrCnt`=0.
